hpdcache_flush_walker: RTL and testbench
========================================

Name: hpdcache_flush_walker

Overview:
- Cache-wide flush sequencer sitting directly upstream of the flush controller's ALLOC interface.
- On a flush-all command it walks every set of the cache directory and reads the per-way valid, dirty and tag state.
- For each valid-and-dirty line it issues one allocation request (nline, way) to the flush controller and clears that line's dirty bit in the directory.
- Once every set is visited and the flush controller has drained, it signals completion.

Parameters:
- SETS, 64, number of cache sets; power of 2, at least 2.
- WAYS, 4, number of ways; at least 1.
- TAG_WIDTH, 30, tag width in bits.
- SET_WIDTH, $clog2(SETS), derived, not overridable.
- NLINE_WIDTH, TAG_WIDTH+SET_WIDTH, derived.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  flush-all request
- start_ready_o  out  1  walker idle, start accepted
- busy_o  out  1  walk in progress
- done_o  out  1  one-cycle completion pulse
- dir_req_o  out  1  directory read request
- dir_gnt_i  in  1  directory read granted this cycle
- dir_set_o  out  SET_WIDTH  set index for read and clear
- dir_valid_i  in  WAYS  per-way valid bits; sampled the cycle after grant
- dir_dirty_i  in  WAYS  per-way dirty bits; same timing
- dir_tags_i  in  WAYS*TAG_WIDTH  per-way tags; way w at [w*TAG_WIDTH +: TAG_WIDTH]; same timing
- dir_clr_dirty_o  out  1  clear dirty bit of (dir_set_o, dir_clr_way_o)
- dir_clr_way_o  out  WAYS  one-hot way to clear
- flush_alloc_o  out  1  allocation request to the flush controller
- flush_alloc_ready_i  in  1  flush controller accepts
- flush_alloc_nline_o  out  NLINE_WIDTH  {tag, set}
- flush_alloc_way_o  out  WAYS  one-hot way
- flush_empty_i  in  1  flush controller has no outstanding entries

Behaviour:
- Reset values: all outputs 0 except start_ready_o=1; FSM=IDLE; set counter=0.
- IDLE:
  - start_ready_o=1.
  - start_i=1 → set counter cleared to 0, go to REQ.
- REQ:
  - dir_req_o=1, dir_set_o=set counter.
  - Hold until dir_gnt_i=1, then go to SAMPLE.
  - dir_req_o is not required to stay stable across the grant boundary; it is deasserted the cycle after the grant.
- SAMPLE (exactly one cycle after grant):
  - Latch pending = dir_valid_i & dir_dirty_i, plus all tags.
  - pending≠0 → go to ALLOC; otherwise go to NEXT.
- ALLOC:
  - w = lowest-index set bit of pending.
  - flush_alloc_o=1, flush_alloc_way_o=onehot(w), flush_alloc_nline_o={tag[w], set counter}.
  - Outputs stay stable while flush_alloc_ready_i=0.
  - On flush_alloc_o & flush_alloc_ready_i, in the same cycle: dir_clr_dirty_o=1, dir_clr_way_o=onehot(w), dir_set_o=set counter. Also clear bit w of pending.
  - If the updated pending=0, go to NEXT; otherwise stay in ALLOC. Throughput: one alloc per cycle when ready is held high.
- NEXT:
  - Set counter = SETS-1 → go to DRAIN.
  - Otherwise increment the set counter and go to REQ.
  - No wrap-around: counter width is SET_WIDTH and the walk visits each set exactly once.
- DRAIN:
  - Wait for flush_empty_i=1 while flush_alloc_o=0, then go to DONE.
  - flush_empty_i sampled high in the first DRAIN cycle is sufficient.
- DONE: done_o=1 for one cycle, then return to IDLE.
- busy_o=1 in every state except IDLE.
- start_i while busy is ignored: not queued, not counted.
- Directory contents latched in SAMPLE are not re-read. The directory owner guarantees that the set being walked is not modified by other requesters between grant and NEXT.
- Latency for an all-clean cache with dir_gnt_i tied high: 3 cycles per set (REQ, SAMPLE, NEXT), plus 1 DRAIN cycle and 1 DONE cycle.
- Reset asserted mid-walk: all state returns to reset values asynchronously. No further alloc or clear is issued, and there is no done_o pulse.

Test Plan:
- Clean cache, SETS=4, grant and ready tied high, flush_empty_i=1: start at cycle 0 → 4 dir reads for sets 0,1,2,3, zero allocs, done_o pulses at cycle 14, busy_o high cycles 1-14.
- Set 2 with valid=4'b1011, dirty=4'b1110, tags 0x11/0x22/0x33/0x44: allocs in order way1 nline={0x22,2}, then way3 nline={0x44,2}; a matching dir_clr_dirty_o per accept; way 0 (clean) and way 2 (invalid) skipped.
- flush_alloc_ready_i held low 5 cycles during ALLOC → flush_alloc_o, nline and way stable for all 5 cycles; exactly one clear pulse, on the accept cycle.
- dir_gnt_i withheld 3 cycles for set 1 → dir_req_o held with dir_set_o=1; sampling occurs only the cycle after the grant.
- After the last set, flush_empty_i low 10 cycles → no done_o until 1 cycle after flush_empty_i rises; start_i pulsed during the wait is ignored (exactly one done_o).
- rst_ni asserted while in ALLOC → flush_alloc_o and busy_o drop immediately, start_ready_o=1; a new start_i walks again from set 0.

Source files
------------

// File: rtl/hpdcache_flush_walker_if.sv
// Bundle of the flush walker's command, directory and flush-controller signals.
// The master side is the walker itself; the slave side is its environment.
interface hpdcache_flush_walker_if #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 30
);
    localparam int unsigned SET_WIDTH   = $clog2(SETS);
    localparam int unsigned NLINE_WIDTH = TAG_WIDTH + SET_WIDTH;

    logic                        start;
    logic                        start_ready;
    logic                        busy;
    logic                        done;

    logic                        dir_req;
    logic                        dir_gnt;
    logic [SET_WIDTH-1:0]        dir_set;
    logic [WAYS-1:0]             dir_valid;
    logic [WAYS-1:0]             dir_dirty;
    logic [WAYS*TAG_WIDTH-1:0]   dir_tags;
    logic                        dir_clr_dirty;
    logic [WAYS-1:0]             dir_clr_way;

    logic                        flush_alloc;
    logic                        flush_alloc_ready;
    logic [NLINE_WIDTH-1:0]      flush_alloc_nline;
    logic [WAYS-1:0]             flush_alloc_way;
    logic                        flush_empty;

    modport master (
        input  start, dir_gnt, dir_valid, dir_dirty, dir_tags,
               flush_alloc_ready, flush_empty,
        output start_ready, busy, done, dir_req, dir_set, dir_clr_dirty,
               dir_clr_way, flush_alloc, flush_alloc_nline, flush_alloc_way
    );

    modport slave (
        output start, dir_gnt, dir_valid, dir_dirty, dir_tags,
               flush_alloc_ready, flush_empty,
        input  start_ready, busy, done, dir_req, dir_set, dir_clr_dirty,
               dir_clr_way, flush_alloc, flush_alloc_nline, flush_alloc_way
    );
endinterface

// File: rtl/hpdcache_flush_walker.sv
// Cache-wide flush sequencer: visits every directory set once, hands each
// valid+dirty line to the flush controller and clears its dirty bit, then
// waits for the flush controller to drain before pulsing done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a flush-all command
// ST_REQ    | directory read of the current set, held until granted
// ST_SAMPLE | cycle after grant: capture valid&dirty mask and tags
// ST_ALLOC  | issue one alloc per pending way, lowest way first
// ST_NEXT   | advance to the next set or leave the walk after the last
// ST_DRAIN  | wait for the flush controller to become empty
// ST_DONE   | one-cycle completion pulse
module hpdcache_flush_walker #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 30
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    hpdcache_flush_walker_if.master bus
);
    localparam int unsigned SET_WIDTH = $clog2(SETS);
    localparam logic [SET_WIDTH-1:0] SET_LAST = SET_WIDTH'(SETS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SAMPLE,
        ST_ALLOC,
        ST_NEXT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [SET_WIDTH-1:0]       set_q;
    logic [WAYS-1:0]            pending_q;
    logic [WAYS*TAG_WIDTH-1:0]  tags_q;

    logic [WAYS-1:0]            sel_way;
    logic [WAYS-1:0]            pending_rem;
    logic [TAG_WIDTH-1:0]       sel_tag;
    logic                       accept;

    // Lowest pending way (two's-complement isolation) and its latched tag.
    always_comb begin
        sel_way     = pending_q & (~pending_q + WAYS'(1));
        pending_rem = pending_q & ~sel_way;
        sel_tag     = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (sel_way[w]) begin
                sel_tag = tags_q[w*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign accept      = (state_q == ST_ALLOC) && bus.flush_alloc_ready;
    assign bus.dir_set = set_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d               = state_q;
        bus.start_ready       = 1'b0;
        bus.busy              = (state_q != ST_IDLE);
        bus.done              = 1'b0;
        bus.dir_req           = 1'b0;
        bus.dir_clr_dirty     = 1'b0;
        bus.dir_clr_way       = '0;
        bus.flush_alloc       = 1'b0;
        bus.flush_alloc_nline = '0;
        bus.flush_alloc_way   = '0;
        case (state_q)
            ST_IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start) state_d = ST_REQ;
            end
            ST_REQ: begin
                bus.dir_req = 1'b1;
                if (bus.dir_gnt) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_d = ((bus.dir_valid & bus.dir_dirty) != '0) ? ST_ALLOC : ST_NEXT;
            end
            ST_ALLOC: begin
                bus.flush_alloc       = 1'b1;
                bus.flush_alloc_nline = {sel_tag, set_q};
                bus.flush_alloc_way   = sel_way;
                if (accept) begin
                    bus.dir_clr_dirty = 1'b1;
                    bus.dir_clr_way   = sel_way;
                    if (pending_rem == '0) state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = (set_q == SET_LAST) ? ST_DRAIN : ST_REQ;
            end
            ST_DRAIN: begin
                if (bus.flush_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set counter, pending-way mask and latched tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q     <= '0;
            pending_q <= '0;
            tags_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) set_q <= '0;
                end
                ST_SAMPLE: begin
                    pending_q <= bus.dir_valid & bus.dir_dirty;
                    tags_q    <= bus.dir_tags;
                end
                ST_ALLOC: begin
                    if (accept) pending_q <= pending_rem;
                end
                ST_NEXT: begin
                    if (set_q != SET_LAST) set_q <= set_q + SET_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Bench for the flush walker: the bench plays the directory and the flush
// controller, and expected allocations come from a simple per-set/per-way
// scan of its own directory model.
module tb_hpdcache_flush_walker;
    localparam int SETS = 4;
    localparam int WAYS = 4;
    localparam int TW   = 12;
    localparam int SW   = 2;
    localparam int NW   = TW + SW;

    typedef struct packed {
        logic [NW-1:0]   nline;
        logic [WAYS-1:0] way;
    } alloc_t;

    logic clk;
    logic rst_n;

    hpdcache_flush_walker_if #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) bus();

    hpdcache_flush_walker #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // directory model
    logic [WAYS-1:0] m_valid [SETS];
    logic [WAYS-1:0] m_dirty [SETS];
    logic [TW-1:0]   m_tag   [SETS][WAYS];

    // observations of one walk
    alloc_t exp_q[$];
    alloc_t acc_q[$];
    int     acc_cyc[$];
    int     rd_sets[$];
    int     req_cnt[SETS];
    int     done_cyc, done_cnt, busy_bad, clr_bad, clr_cnt, hold_bad, first_alloc_cyc;
    logic   abort_seen, abort_alloc, abort_busy, abort_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void clear_dir();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s] = '0;
            m_dirty[s] = '0;
            for (int w = 0; w < WAYS; w++) m_tag[s][w] = TW'($urandom);
        end
    endfunction

    function automatic void random_dir();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s] = WAYS'($urandom);
            m_dirty[s] = WAYS'($urandom);
            for (int w = 0; w < WAYS; w++) m_tag[s][w] = TW'($urandom);
        end
    endfunction

    // Every valid+dirty line, sets in ascending order, ways ascending within a set.
    function automatic void build_exp();
        exp_q.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_dirty[s][w])
                    exp_q.push_back('{nline: {m_tag[s][w], SW'(s)}, way: WAYS'(1) << w});
    endfunction

    task automatic idle_inputs();
        bus.start             = 1'b0;
        bus.dir_gnt           = 1'b0;
        bus.dir_valid         = '0;
        bus.dir_dirty         = '0;
        bus.dir_tags          = '0;
        bus.flush_alloc_ready = 1'b0;
        bus.flush_empty       = 1'b1;
    endtask

    // Drives one walk starting at cycle 0 and logs what the walker does.
    task automatic run_walk(input int gnt_pct, input int ready_pct, input int empty_rise,
                            input int stall_n, input int hold_set, input int hold_n,
                            input int start_again, input bit abort, input int budget);
        int   cyc, stall_left, hold_left, gset;
        bit   grant_prev, prev_stall, accept;
        alloc_t prev;
        logic [WAYS*TW-1:0] t;
        acc_q.delete(); acc_cyc.delete(); rd_sets.delete();
        for (int s = 0; s < SETS; s++) req_cnt[s] = 0;
        done_cyc = -1; done_cnt = 0; busy_bad = 0; clr_bad = 0; clr_cnt = 0;
        hold_bad = 0; first_alloc_cyc = -1; abort_seen = 1'b0;
        stall_left = stall_n; hold_left = hold_n; gset = 0;
        grant_prev = 1'b0; prev_stall = 1'b0; prev = '0;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            bus.start       = (cyc == 0) || (cyc == start_again);
            bus.flush_empty = (cyc >= empty_rise);
            if (grant_prev) begin
                for (int w = 0; w < WAYS; w++) t[w*TW +: TW] = m_tag[gset][w];
                bus.dir_valid = m_valid[gset];
                bus.dir_dirty = m_dirty[gset];
                bus.dir_tags  = t;
            end else begin
                for (int w = 0; w < WAYS; w++) t[w*TW +: TW] = TW'($urandom);
                bus.dir_valid = WAYS'($urandom);
                bus.dir_dirty = WAYS'($urandom);
                bus.dir_tags  = t;
            end
            if (bus.dir_req && int'(bus.dir_set) == hold_set && hold_left > 0) begin
                bus.dir_gnt = 1'b0;
                hold_left--;
            end else begin
                bus.dir_gnt = ($urandom_range(99) < gnt_pct);
            end
            if (bus.flush_alloc && stall_left > 0) begin
                bus.flush_alloc_ready = 1'b0;
                stall_left--;
            end else begin
                bus.flush_alloc_ready = ($urandom_range(99) < ready_pct);
            end

            @(negedge clk);
            if (abort && bus.flush_alloc) begin
                #2 rst_n = 1'b0;
                #1;
                abort_seen  = 1'b1;
                abort_alloc = bus.flush_alloc;
                abort_busy  = bus.busy;
                abort_ready = bus.start_ready;
                break;
            end
            if (bus.dir_req) req_cnt[int'(bus.dir_set)]++;
            grant_prev = bus.dir_req && bus.dir_gnt;
            if (grant_prev) begin
                gset = int'(bus.dir_set);
                rd_sets.push_back(gset);
            end
            if (bus.flush_alloc && first_alloc_cyc < 0) first_alloc_cyc = cyc;
            if (prev_stall && (!bus.flush_alloc || bus.flush_alloc_nline != prev.nline ||
                               bus.flush_alloc_way != prev.way))
                hold_bad++;
            prev_stall = bus.flush_alloc && !bus.flush_alloc_ready;
            prev       = '{nline: bus.flush_alloc_nline, way: bus.flush_alloc_way};
            accept     = bus.flush_alloc && bus.flush_alloc_ready;
            if (bus.dir_clr_dirty) clr_cnt++;
            if (accept) begin
                acc_q.push_back(prev);
                acc_cyc.push_back(cyc);
                if (!bus.dir_clr_dirty || bus.dir_clr_way != bus.flush_alloc_way ||
                    bus.dir_set != bus.flush_alloc_nline[SW-1:0])
                    clr_bad++;
            end else if (bus.dir_clr_dirty) begin
                clr_bad++;
            end
            if (bus.dir_clr_dirty)
                m_dirty[int'(bus.dir_set)] = m_dirty[int'(bus.dir_set)] & ~bus.dir_clr_way;
            if (cyc >= 1 && done_cyc < 0 && !bus.busy) busy_bad++;
            if (done_cyc >= 0 && cyc > done_cyc && bus.busy) busy_bad++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            cyc++;
        end
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %0b want 1", bus.start_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_cmp++; if (bus.dir_req !== 1'b0) begin n_fail++; $display("FAIL reset_dir_req: got %0b want 0", bus.dir_req); end
        n_cmp++; if (bus.dir_set !== '0) begin n_fail++; $display("FAIL reset_dir_set: got %0d want 0", bus.dir_set); end
        n_cmp++; if (bus.flush_alloc !== 1'b0) begin n_fail++; $display("FAIL reset_alloc: got %0b want 0", bus.flush_alloc); end
        n_cmp++; if (bus.dir_clr_dirty !== 1'b0 || bus.dir_clr_way !== '0) begin n_fail++; $display("FAIL reset_clr: got %0b/%0h want 0/0", bus.dir_clr_dirty, bus.dir_clr_way); end
        n_cmp++; if (bus.flush_alloc_nline !== '0 || bus.flush_alloc_way !== '0) begin n_fail++; $display("FAIL reset_alloc_bus: got %0h/%0h want 0/0", bus.flush_alloc_nline, bus.flush_alloc_way); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean();
        clear_dir();
        for (int s = 0; s < SETS; s++) m_dirty[s] = WAYS'($urandom);
        run_walk(100, 100, 0, 0, -1, 0, -1, 1'b0, 100);
        n_cmp++; if (done_cyc !== 14) begin n_fail++; $display("FAIL clean_done_cycle: got %0d want 14", done_cyc); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL clean_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL clean_busy_window: got %0d bad cycles want 0", busy_bad); end
        n_cmp++; if (acc_q.size() !== 0 || clr_cnt !== 0) begin n_fail++; $display("FAIL clean_no_alloc: got %0d allocs %0d clears want 0", acc_q.size(), clr_cnt); end
        n_cmp++; if (rd_sets.size() !== SETS) begin n_fail++; $display("FAIL clean_read_count: got %0d want %0d", rd_sets.size(), SETS); end
        for (int i = 0; i < rd_sets.size() && i < SETS; i++) begin
            n_cmp++; if (rd_sets[i] !== i) begin n_fail++; $display("FAIL clean_read_order[%0d]: got %0d want %0d", i, rd_sets[i], i); end
        end
    endtask

    task automatic test_set2();
        alloc_t e0, e1;
        clear_dir();
        m_valid[2] = 4'b1011;
        m_dirty[2] = 4'b1110;
        m_tag[2][0] = 12'h011; m_tag[2][1] = 12'h022; m_tag[2][2] = 12'h033; m_tag[2][3] = 12'h044;
        e0 = '{nline: {12'h022, 2'd2}, way: 4'b0010};
        e1 = '{nline: {12'h044, 2'd2}, way: 4'b1000};
        run_walk(100, 100, 0, 0, -1, 0, -1, 1'b0, 100);
        n_cmp++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL set2_alloc_count: got %0d want 2", acc_q.size()); end
        if (acc_q.size() == 2) begin
            n_cmp++; if (acc_q[0] !== e0) begin n_fail++; $display("FAIL set2_alloc0: got %h want %h", acc_q[0], e0); end
            n_cmp++; if (acc_q[1] !== e1) begin n_fail++; $display("FAIL set2_alloc1: got %h want %h", acc_q[1], e1); end
            n_cmp++; if (acc_cyc[1] !== acc_cyc[0] + 1) begin n_fail++; $display("FAIL set2_back_to_back: got cycle %0d want %0d", acc_cyc[1], acc_cyc[0] + 1); end
        end
        n_cmp++; if (clr_bad !== 0 || clr_cnt !== 2) begin n_fail++; $display("FAIL set2_clears: got %0d bad %0d pulses want 0/2", clr_bad, clr_cnt); end
        n_cmp++; if (m_dirty[2] !== 4'b0100) begin n_fail++; $display("FAIL set2_dirty_after: got %b want 0100", m_dirty[2]); end
        n_cmp++; if (done_cyc !== 16) begin n_fail++; $display("FAIL set2_done_cycle: got %0d want 16", done_cyc); end
    endtask

    task automatic test_stall();
        clear_dir();
        m_valid[0] = 4'b0001; m_dirty[0] = 4'b0001;
        m_valid[3] = 4'b0110; m_dirty[3] = 4'b1111;
        build_exp();
        run_walk(100, 100, 0, 5, -1, 0, -1, 1'b0, 200);
        n_cmp++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad); end
        n_cmp++; if (acc_cyc.size() < 1 || acc_cyc[0] !== first_alloc_cyc + 5) begin n_fail++; $display("FAIL stall_accept_cycle: got %0d want %0d", (acc_cyc.size() > 0) ? acc_cyc[0] : -1, first_alloc_cyc + 5); end
        n_cmp++; if (clr_cnt !== 3 || clr_bad !== 0) begin n_fail++; $display("FAIL stall_clears: got %0d pulses %0d bad want 3/0", clr_cnt, clr_bad); end
        n_cmp++; if (acc_q !== exp_q) begin n_fail++; $display("FAIL stall_allocs: got %0d allocs want %0d", acc_q.size(), exp_q.size()); end
    endtask

    task automatic test_gnt_wait();
        alloc_t e0;
        clear_dir();
        m_valid[1] = 4'b0100; m_dirty[1] = 4'b0100; m_tag[1][2] = 12'h5A5;
        e0 = '{nline: {12'h5A5, 2'd1}, way: 4'b0100};
        run_walk(100, 100, 0, 0, 1, 3, -1, 1'b0, 100);
        n_cmp++; if (req_cnt[1] !== 4) begin n_fail++; $display("FAIL gnt_req_held: got %0d req cycles want 4", req_cnt[1]); end
        n_cmp++; if (acc_q.size() !== 1 || acc_q[0] !== e0) begin n_fail++; $display("FAIL gnt_sampled_alloc: got %0d allocs want 1 of %h", acc_q.size(), e0); end
        n_cmp++; if (done_cyc !== 18) begin n_fail++; $display("FAIL gnt_done_cycle: got %0d want 18", done_cyc); end
    endtask

    task automatic test_drain();
        clear_dir();
        run_walk(100, 100, 23, 0, -1, 0, 17, 1'b0, 100);
        n_cmp++; if (done_cyc !== 24) begin n_fail++; $display("FAIL drain_done_cycle: got %0d want 24", done_cyc); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL drain_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL drain_busy_window: got %0d bad cycles want 0", busy_bad); end
    endtask

    task automatic test_random();
        int er, leftover;
        for (int it = 0; it < 6; it++) begin
            random_dir();
            build_exp();
            er = $urandom_range(60);
            run_walk(60, 50, er, 0, -1, 0, -1, 1'b0, 800);
            n_cmp++; if (acc_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_alloc_count: got %0d want %0d", it, acc_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
                n_cmp++; if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_alloc[%0d]: got %h want %h", it, i, acc_q[i], exp_q[i]); end
            end
            n_cmp++; if (hold_bad !== 0 || clr_bad !== 0) begin n_fail++; $display("FAIL rand%0d_protocol: got hold %0d clr %0d want 0/0", it, hold_bad, clr_bad); end
            n_cmp++; if (done_cnt !== 1 || done_cyc <= er) begin n_fail++; $display("FAIL rand%0d_done: got %0d pulses at %0d want 1 after %0d", it, done_cnt, done_cyc, er); end
            leftover = 0;
            for (int s = 0; s < SETS; s++) if ((m_valid[s] & m_dirty[s]) != '0) leftover++;
            n_cmp++; if (leftover !== 0) begin n_fail++; $display("FAIL rand%0d_dirty_left: got %0d sets want 0", it, leftover); end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        random_dir();
        m_valid[0] = 4'b1111; m_dirty[0] = 4'b1111;
        run_walk(100, 100, 0, 0, -1, 0, -1, 1'b1, 100);
        n_cmp++; if (abort_seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reached_alloc: got %0b want 1", abort_seen); end
        n_cmp++; if (abort_alloc !== 1'b0 || abort_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got alloc %0b busy %0b want 0/0", abort_alloc, abort_busy); end
        n_cmp++; if (abort_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_start_ready: got %0b want 1", abort_ready); end
        idle_inputs();
        bus.flush_alloc_ready = 1'b1;
        bus.dir_gnt = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.flush_alloc || bus.dir_clr_dirty || bus.done || bus.busy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
        build_exp();
        run_walk(100, 100, 0, 0, -1, 0, -1, 1'b0, 200);
        n_cmp++; if (rd_sets.size() < 1 || rd_sets[0] !== 0) begin n_fail++; $display("FAIL rstmid_restart_set: got %0d reads first %0d want set 0", rd_sets.size(), (rd_sets.size() > 0) ? rd_sets[0] : -1); end
        n_cmp++; if (acc_q !== exp_q) begin n_fail++; $display("FAIL rstmid_rewalk_allocs: got %0d allocs want %0d", acc_q.size(), exp_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rstmid_rewalk_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        clear_dir();
        test_reset();
        test_clean();
        test_set2();
        test_stall();
        test_gnt_wait();
        test_drain();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
